// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types for the byte FIFO and its stream reader
package fifo_pkg;

  typedef logic [7:0] byte_t;

  localparam int FIFO_DEPTH = 16;

  typedef enum logic {
    ACTIVE = 1'b0,
    QUIET  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fifo_stream_reader_skid_buffer2.sv
// rtl/fifo_stream_reader_skid_buffer2.sv - 2-entry register FIFO that absorbs the FIFO read latency
module skid_buffer2
  import fifo_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [1:0] occ,
  output logic [7:0] head
);

  byte_t e0;
  byte_t e1;

  assign head = e0;

  // A push into a full buffer or a pop from an empty one is ignored; the
  // reader's credit logic never requests either.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            e0  <= push_data;
            occ <= 2'd1;
          end else if (occ == 2'd1) begin
            e1  <= push_data;
            occ <= 2'd2;
          end
        end
        2'b01: begin
          if (occ != 2'd0) begin
            e0  <= e1;
            occ <= occ - 2'd1;
          end
        end
        2'b11: begin
          if (occ == 2'd0) begin
            e0  <= push_data;
            occ <= 2'd1;
          end else if (occ == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - paced FIFO pop engine feeding a valid/ready byte stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int BURST_LEN    = 16,
  parameter int QUIET_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_read_en,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic [15:0] byte_count,
  output logic [7:0]  checksum
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0] QUIET_LOAD = 8'(QUIET_CYCLES);

  rd_state_e  state, state_next;
  logic [7:0] burst_cnt, burst_next;
  logic [7:0] quiet_cnt, quiet_next;
  logic       inflight;
  logic [1:0] occ;
  logic       xfer;
  logic [2:0] used;
  logic [2:0] avail;

  skid_buffer2 u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (xfer),
    .occ       (occ),
    .head      (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid & m_ready;

  // The slot freed by this cycle's transfer counts as credit so a steady
  // m_ready sustains one pop per cycle without overrunning the skid.
  assign used  = {1'b0, occ} + {2'b0, inflight};
  assign avail = 3'd2 + {2'b0, xfer};
  assign fifo_read_en = reset_n & (state == ACTIVE) & ~fifo_empty & (used < avail);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACTIVE;
      burst_cnt <= '0;
      quiet_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      quiet_cnt <= quiet_next;
      inflight  <= fifo_read_en;
    end
  end

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    quiet_next = quiet_cnt;
    case (state)
      ACTIVE: begin
        if (fifo_read_en) begin
          if (burst_cnt == BURST_LAST) begin
            burst_next = '0;
            if (QUIET_CYCLES > 0) begin
              state_next = QUIET;
              quiet_next = QUIET_LOAD;
            end
          end else begin
            burst_next = burst_cnt + 8'd1;
          end
        end
      end
      QUIET: begin
        if (quiet_cnt <= 8'd1) begin
          state_next = ACTIVE;
          quiet_next = '0;
        end else begin
          quiet_next = quiet_cnt - 8'd1;
        end
      end
      default: state_next = ACTIVE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= '0;
      checksum   <= '0;
    end else if (xfer) begin
      byte_count <= byte_count + 16'd1;
      checksum   <= checksum ^ m_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic        fifo_empty_a = 1'b1;
  byte_t       fifo_data_a = '0;
  logic        fifo_read_en_a, m_valid_a;
  logic        m_ready_a = 1'b0;
  byte_t       m_data_a, checksum_a;
  logic [15:0] byte_count_a;

  logic        fifo_empty_b = 1'b1;
  byte_t       fifo_data_b = '0;
  logic        fifo_read_en_b, m_valid_b;
  logic        m_ready_b = 1'b0;
  byte_t       m_data_b, checksum_b;
  logic [15:0] byte_count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  byte_t qa[$], qb[$], rx_a[$], rx_b[$], sent_b[$];
  int    pops_a[$], pops_b[$], rx_cyc_a[$], quiet_runs[$];
  int    quiet_run = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fifo_stream_reader u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty_a),
    .fifo_data    (fifo_data_a),
    .fifo_read_en (fifo_read_en_a),
    .m_valid      (m_valid_a),
    .m_data       (m_data_a),
    .m_ready      (m_ready_a),
    .byte_count   (byte_count_a),
    .checksum     (checksum_a)
  );

  fifo_stream_reader #(.BURST_LEN(4), .QUIET_CYCLES(3)) u_dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty_b),
    .fifo_data    (fifo_data_b),
    .fifo_read_en (fifo_read_en_b),
    .m_valid      (m_valid_b),
    .m_data       (m_data_b),
    .m_ready      (m_ready_b),
    .byte_count   (byte_count_b),
    .checksum     (checksum_b)
  );

  // Registered-output FIFO models: data appears the cycle after a pop.
  always @(posedge clock) begin
    if (fifo_read_en_a) fifo_data_a <= qa.pop_front();
    fifo_empty_a <= (qa.size() == 0);
    if (fifo_read_en_b) fifo_data_b <= qb.pop_front();
    fifo_empty_b <= (qb.size() == 0);
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (fifo_read_en_a) pops_a.push_back(cyc);
      if (m_valid_a && m_ready_a) begin
        rx_a.push_back(m_data_a);
        rx_cyc_a.push_back(cyc);
      end
      if (fifo_read_en_b) pops_b.push_back(cyc);
      if (m_valid_b && m_ready_b) rx_b.push_back(m_data_b);
      if (u_dut_b.state == QUIET) begin
        quiet_run = quiet_run + 1;
      end else if (quiet_run > 0) begin
        quiet_runs.push_back(quiet_run);
        quiet_run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clear_a();
    pops_a.delete();
    rx_a.delete();
    rx_cyc_a.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int    bad;
    byte_t exp_csum;

    tick(3);
    check("rst_m_valid", 32'(m_valid_a), 0);
    check("rst_m_data", 32'(m_data_a), 0);
    check("rst_byte_count", 32'(byte_count_a), 0);
    check("rst_checksum", 32'(checksum_a), 0);
    check("rst_read_en", 32'(fifo_read_en_a), 0);
    reset_n = 1'b1;
    tick(2);

    // Streaming: 18 bytes so the 2-cycle quiet gap after pop 16 is visible.
    clear_a();
    m_ready_a = 1'b1;
    exp_csum = '0;
    for (int i = 1; i <= 18; i++) qa.push_back(byte_t'(i));
    for (int i = 0; i < 100 && rx_a.size() < 16; i++) tick(1);
    check("stream_count16", 32'(byte_count_a), 16);
    check("stream_csum16", 32'(checksum_a), 32'h10);
    for (int i = 0; i < 60 && rx_a.size() < 18; i++) tick(1);
    check("stream_rx18", rx_a.size(), 18);
    check("stream_pops18", pops_a.size(), 18);
    if (rx_a.size() == 18 && pops_a.size() == 18) begin
      check("stream_pop_burst", pops_a[15] - pops_a[0], 15);
      check("stream_quiet_gap", pops_a[16] - pops_a[15], 3);
      check("stream_latency", rx_cyc_a[0] - pops_a[0], 2);
      check("stream_rx_contig", rx_cyc_a[15] - rx_cyc_a[0], 15);
      bad = 0;
      for (int i = 0; i < 18; i++) begin
        if (rx_a[i] != byte_t'(i + 1)) bad++;
        exp_csum ^= byte_t'(i + 1);
      end
      check("stream_order", bad, 0);
    end

    // Backpressure: only two bytes may be pulled while m_ready is low.
    m_ready_a = 1'b0;
    tick(5);
    clear_a();
    for (int i = 0; i < 5; i++) qa.push_back(byte_t'(8'h21 + i));
    tick(10);
    check("bp_pops_held", pops_a.size(), 2);
    check("bp_read_en", 32'(fifo_read_en_a), 0);
    check("bp_m_valid", 32'(m_valid_a), 1);
    check("bp_m_data", 32'(m_data_a), 32'h21);
    m_ready_a = 1'b1;
    for (int i = 0; i < 40 && rx_a.size() < 5; i++) tick(1);
    check("bp_rx5", rx_a.size(), 5);
    check("bp_pops5", pops_a.size(), 5);
    if (rx_a.size() == 5) begin
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        if (rx_a[i] != byte_t'(8'h21 + i)) bad++;
        exp_csum ^= byte_t'(8'h21 + i);
      end
      check("bp_order", bad, 0);
    end
    tick(2);
    check("bp_byte_count", 32'(byte_count_a), 23);
    check("bp_checksum", 32'(checksum_a), 32'(exp_csum));

    // Reset while one byte is held and one is in flight.
    m_ready_a = 1'b0;
    clear_a();
    for (int i = 0; i < 5; i++) qa.push_back(byte_t'(8'h31 + i));
    for (int i = 0; i < 20 && pops_a.size() < 2; i++) tick(1);
    check("mid_setup_pops", pops_a.size(), 2);
    check("mid_setup_valid", 32'(m_valid_a), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid_a), 0);
    check("mid_rst_byte_count", 32'(byte_count_a), 0);
    check("mid_rst_checksum", 32'(checksum_a), 0);
    check("mid_rst_read_en", 32'(fifo_read_en_a), 0);
    tick(2);
    reset_n = 1'b1;
    m_ready_a = 1'b1;
    clear_a();
    for (int i = 0; i < 40 && rx_a.size() < 3; i++) tick(1);
    check("mid_rx3", rx_a.size(), 3);
    if (rx_a.size() == 3) begin
      check("mid_first_byte", 32'(rx_a[0]), 32'h33);
      check("mid_last_byte", 32'(rx_a[2]), 32'h35);
    end

    // Empty boundary: a single byte then the FIFO runs dry.
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    clear_a();
    qa.push_back(8'h5A);
    tick(10);
    check("empty_pops", pops_a.size(), 1);
    check("empty_rx", rx_a.size(), 1);
    if (rx_a.size() == 1) check("empty_byte", 32'(rx_a[0]), 32'h5A);
    check("empty_byte_count", 32'(byte_count_a), 1);
    check("empty_burst_cnt", 32'(u_dut.burst_cnt), 1);
    check("empty_state", 32'(u_dut.state), 32'(ACTIVE));
    check("empty_m_valid", 32'(m_valid_a), 0);

    // Wrap of the byte counter.
    force u_dut.byte_count = 16'hFFFF;
    tick(1);
    release u_dut.byte_count;
    qa.push_back(8'h77);
    tick(8);
    check("wrap_byte_count", 32'(byte_count_a), 0);
    check("wrap_checksum", 32'(checksum_a), 32'h2D);

    // Alternating ready on the 4-pop / 3-quiet instance.
    pops_b.delete();
    rx_b.delete();
    quiet_runs.delete();
    exp_csum = '0;
    for (int i = 0; i < 40; i++) begin
      sent_b.push_back(byte_t'(i * 37 + 5));
      qb.push_back(byte_t'(i * 37 + 5));
      exp_csum ^= byte_t'(i * 37 + 5);
    end
    m_ready_b = 1'b1;
    for (int i = 0; i < 600 && rx_b.size() < 40; i++) begin
      tick(1);
      m_ready_b = ~m_ready_b;
    end
    m_ready_b = 1'b1;
    tick(8);
    check("alt_rx40", rx_b.size(), 40);
    check("alt_pops40", pops_b.size(), 40);
    check("alt_byte_count", 32'(byte_count_b), 40);
    check("alt_checksum", 32'(checksum_b), 32'(exp_csum));
    if (rx_b.size() == 40) begin
      bad = 0;
      for (int i = 0; i < 40; i++) if (rx_b[i] != sent_b[i]) bad++;
      check("alt_order", bad, 0);
    end
    if (pops_b.size() == 40) begin
      bad = 0;
      for (int j = 4; j < 40; j += 4) if (pops_b[j] - pops_b[j-1] < 4) bad++;
      check("alt_gap_short", bad, 0);
    end
    check("alt_quiet_runs", quiet_runs.size(), 10);
    bad = 0;
    foreach (quiet_runs[i]) if (quiet_runs[i] != 3) bad++;
    check("alt_quiet_len", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
